// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg : shared types and helpers for the sequential restoring divider
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_W_DEFAULT = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_32bit_if.sv
// ---------------------------------------------------------------------------
// seq_divider_32bit_if : operand/result handshake bundle for the divider
// Optional macro DIV_ZERO_FAST_EN adds the div_by_zero flag.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_divider_32bit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FAST_EN
  logic             div_by_zero;
`endif

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder
`ifdef DIV_ZERO_FAST_EN
    , input div_by_zero
`endif
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder
`ifdef DIV_ZERO_FAST_EN
    , output div_by_zero
`endif
  );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step : one combinational restoring-division step (shift in, trial subtract)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] i_r,
  input  wire logic             i_q_msb,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_r_next,
  output logic                  o_q_bit
);

  logic [WIDTH:0] w_t;
  logic [WIDTH:0] w_s;

  assign w_t = {i_r, i_q_msb};
  // One bit wider than the operands so the top bit of the difference is the borrow.
  assign w_s = w_t + ~{1'b0, i_d} + {{WIDTH{1'b0}}, 1'b1};

  assign o_q_bit  = ~w_s[WIDTH];
  assign o_r_next = o_q_bit ? w_s[WIDTH-1:0] : w_t[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider_32bit.sv
// ---------------------------------------------------------------------------
// seq_divider_32bit : multi-cycle unsigned restoring divider, one quotient bit/clock
// Optional macro DIV_ZERO_FAST_EN: zero divisor finishes in one cycle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  wire logic           clk,
  input  wire logic           reset,
  seq_divider_32bit_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_next;
`ifdef DIV_ZERO_FAST_EN
  logic             r_div_by_zero;
  assign bus.div_by_zero = r_div_by_zero;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r      (r_r),
    .i_q_msb  (r_q[WIDTH-1]),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  assign w_q_next      = {r_q[WIDTH-2:0], w_q_bit};
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
      r_div_by_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_count    <= '0;
            r_q        <= bus.dividend;
            r_r        <= '0;
            r_d        <= bus.divisor;
            r_state    <= RUN;
`ifdef DIV_ZERO_FAST_EN
            r_div_by_zero <= 1'b0;
            // Zero divisor skips the iteration; out_valid rises on the following edge.
            if (bus.divisor == '0) begin
              r_quotient    <= '1;
              r_remainder   <= bus.dividend;
              r_div_by_zero <= 1'b1;
              r_state       <= DONE;
            end
`endif
          end
        end
        RUN: begin
          r_q     <= w_q_next;
          r_r     <= w_r_next;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_32bit.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_32bit : directed and random self-checking bench for the divider
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider_32bit;

  localparam int W     = 32;
  localparam int N_RND = 300;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   received = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  seq_divider_32bit_if #(.WIDTH(W)) bus ();

  seq_divider_32bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model bookkeeping on the clock edge: accepts push, handshakes pop.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        received++;
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.dividend, bus.divisor));
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got 1, expected 0");
      end else begin
        chk("quotient", {32'd0, bus.quotient}, {32'd0, exp_q[0].q});
        chk("remainder", {32'd0, bus.remainder}, {32'd0, exp_q[0].r});
`ifdef DIV_ZERO_FAST_EN
        chk("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, exp_q[0].z});
`endif
        if (exp_q[0].b != 0) begin
          chk("identity", ({32'd0, bus.quotient} * {32'd0, exp_q[0].b}) + {32'd0, bus.remainder},
              {32'd0, exp_q[0].a});
          chk("rem_lt_div", {63'd0, (bus.remainder < exp_q[0].b)}, 64'd1);
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_val(input bit allow_zero);
    case ($urandom_range(0, 4))
      0: return W'($urandom);
      1: return W'($urandom) >> $urandom_range(0, 31);
      2: return W'($urandom_range(1, 15));
      3: return 32'hFFFF_FFFF;
      default: return allow_zero ? '0 : W'($urandom_range(1, 255));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   base;
    exp_t e;
    logic [W-1:0] hq, hr;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    e = model(32'd100, 32'd7);
    chk("model_100_7_q", {32'd0, e.q}, 64'd14);
    chk("model_100_7_r", {32'd0, e.r}, 64'd2);
    e = model(32'hABCD, 32'd0);
    chk("model_div0_q", {32'd0, e.q}, 64'hFFFF_FFFF);
    chk("model_div0_r", {32'd0, e.r}, 64'hABCD);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_quotient", {32'd0, bus.quotient}, 64'd0);
    chk("rst_remainder", {32'd0, bus.remainder}, 64'd0);
`ifdef DIV_ZERO_FAST_EN
    chk("rst_div_by_zero", {63'd0, bus.div_by_zero}, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    run_op(32'd100, 32'd7, lat);
    chk("lat_100_7", 64'(lat), 64'd32);
    chk("q_100_7", {32'd0, bus.quotient}, 64'd14);
    chk("r_100_7", {32'd0, bus.remainder}, 64'd2);
    take();
    chk("post_take_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("post_take_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("post_take_q_kept", {32'd0, bus.quotient}, 64'd14);

    run_op(32'hFFFF_FFFF, 32'd1, lat);
    chk("q_max_1", {32'd0, bus.quotient}, 64'hFFFF_FFFF);
    chk("r_max_1", {32'd0, bus.remainder}, 64'd0);
    take();
    run_op(32'h1234_5678, 32'h1234_5679, lat);
    chk("q_small_big", {32'd0, bus.quotient}, 64'd0);
    chk("r_small_big", {32'd0, bus.remainder}, 64'h1234_5678);
    take();
    run_op(32'h8000_0000, 32'h8000_0000, lat);
    chk("q_msb_msb", {32'd0, bus.quotient}, 64'd1);
    chk("r_msb_msb", {32'd0, bus.remainder}, 64'd0);
    take();

    run_op(32'd1000, 32'd10, lat);
    hq = bus.quotient;
    hr = bus.remainder;
    chk("bp_q", {32'd0, hq}, 64'd100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.dividend = 32'd77;
      bus.divisor  = 32'd5;
      @(posedge clk);
      #1;
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_q_stable", {32'd0, bus.quotient}, {32'd0, hq});
      chk("bp_r_stable", {32'd0, bus.remainder}, {32'd0, hr});
    end
    bus.in_valid = 1'b0;
    take();
    run_op(32'd50, 32'd8, lat);
    chk("after_bp_q", {32'd0, bus.quotient}, 64'd6);
    chk("after_bp_r", {32'd0, bus.remainder}, 64'd2);
    take();

    @(negedge clk);
    bus.dividend = 32'd12345;
    bus.divisor  = 32'd17;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("abort_quotient", {32'd0, bus.quotient}, 64'd0);
    chk("abort_remainder", {32'd0, bus.remainder}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd9, 32'd3, lat);
    chk("lat_9_3", 64'(lat), 64'd32);
    chk("q_9_3", {32'd0, bus.quotient}, 64'd3);
    chk("r_9_3", {32'd0, bus.remainder}, 64'd0);
    take();

    run_op(32'hABCD, 32'd0, lat);
`ifdef DIV_ZERO_FAST_EN
    chk("lat_div0", 64'(lat), 64'd1);
    chk("dbz_flag", {63'd0, bus.div_by_zero}, 64'd1);
`else
    chk("lat_div0", 64'(lat), 64'd32);
`endif
    chk("q_div0", {32'd0, bus.quotient}, 64'hFFFF_FFFF);
    chk("r_div0", {32'd0, bus.remainder}, 64'hABCD);
    take();
`ifdef DIV_ZERO_FAST_EN
    run_op(32'd21, 32'd4, lat);
    chk("dbz_cleared", {63'd0, bus.div_by_zero}, 64'd0);
    take();
`endif

    base = received;
    fork
      begin
        for (int i = 0; i < N_RND; i++) begin
          bit acc;
          int g;
          acc = 1'b0;
          g = 0;
          bus.dividend = rnd_val(1'b1);
          bus.divisor  = rnd_val(1'b1);
          while (!acc && g < 500) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            acc = bus.in_valid && bus.in_ready;
            g++;
          end
          if (!acc) begin
            total++;
            bad++;
            $display("FAIL rnd_accept_timeout: got no accept, expected accept of op %0d", i);
          end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin
        int g;
        g = 0;
        while ((received - base) < N_RND && g < N_RND * 100) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 2) != 0);
          g++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
      end
    join
    chk("rnd_all_received", 64'(received - base), 64'(N_RND));
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
